// File: rtl/vga_comp_pkg.sv
// Shared blink-mode encodings and default colour constants for the VGA layer compositor.
package vga_comp_pkg;

  typedef enum logic [1:0] {
    BLINK_STEADY   = 2'b00,
    BLINK_SLOW     = 2'b01,
    BLINK_FAST     = 2'b10,
    BLINK_FAST_INV = 2'b11
  } blink_mode_t;

  localparam int DEFAULT_RGB_W = 12;
  localparam logic [DEFAULT_RGB_W-1:0] DEFAULT_BG_COLOR = 12'h000;

endpackage

// File: rtl/blink_divider.sv
// Blink phase generator: free-running divider whose wraps are held pending and applied only at frame start.
module blink_divider
  import vga_comp_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start,
  output logic phase
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;
  logic             pending;
  logic             wrap;

  assign wrap = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // A wrap landing on the frame-start clock is applied directly instead of being parked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase   <= 1'b0;
      pending <= 1'b0;
    end else if (frame_start) begin
      phase   <= phase ^ (pending | wrap);
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Prioritised multi-layer VGA pixel compositor with frame-aligned blink gating.
// Optional build macro VGA_COMP_DIM_EN: blinked-off layers show at half intensity instead of going transparent.
module vga_layer_compositor
  import vga_comp_pkg::*;
#(
  parameter int                NUM_LAYERS = 4,
  parameter int                RGB_W      = DEFAULT_RGB_W,
  parameter int                SLOW_DIV   = 33333333,
  parameter int                FAST_DIV   = 16666667,
  parameter logic [RGB_W-1:0]  BG_COLOR   = DEFAULT_BG_COLOR
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [2*NUM_LAYERS-1:0]     blink_sel,
  output logic                        hsync,
  output logic                        vsync,
  output logic [RGB_W-1:0]            rgb,
  output logic                        blink_slow,
  output logic                        blink_fast
);

  logic                  vsync_q;
  logic                  frame_start;
  logic [NUM_LAYERS-1:0] gate;
  logic [NUM_LAYERS-1:0] present;
  logic [RGB_W-1:0]      selected;

`ifdef VGA_COMP_DIM_EN
  localparam int CH_W = RGB_W / 3;

  function automatic logic [RGB_W-1:0] half_intensity(input logic [RGB_W-1:0] c);
    logic [RGB_W-1:0] d;
    d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      d[ch*CH_W +: CH_W] = c[ch*CH_W +: CH_W] >> 1;
    end
    return d;
  endfunction
`endif

  // Frame start is the falling edge of the raw (active-low) vsync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync_in;
    end
  end

  assign frame_start = vsync_q & ~vsync_in;

  blink_divider #(.DIV(SLOW_DIV)) u_blink_slow (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .phase       (blink_slow)
  );

  blink_divider #(.DIV(FAST_DIV)) u_blink_fast (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .phase       (blink_fast)
  );

  always_comb begin
    gate    = '0;
    present = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      present[i] = layer_on[i] & layer_en[i];
      case (blink_mode_t'(blink_sel[2*i +: 2]))
        BLINK_STEADY:   gate[i] = 1'b1;
        BLINK_SLOW:     gate[i] = blink_slow;
        BLINK_FAST:     gate[i] = blink_fast;
        BLINK_FAST_INV: gate[i] = ~blink_fast;
        default:        gate[i] = 1'b1;
      endcase
    end
  end

  // Walk from the lowest priority upward so the lowest-index hit overwrites the rest.
  always_comb begin
    selected = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (present[i] && gate[i]) begin
        selected = layer_rgb[i*RGB_W +: RGB_W];
      end
`ifdef VGA_COMP_DIM_EN
      else if (present[i]) begin
        selected = half_intensity(layer_rgb[i*RGB_W +: RGB_W]);
      end
`endif
    end
    if (!video_on) begin
      selected = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pixel_tick) begin
      rgb   <= selected;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor: directed scenarios plus randomized traffic against a reference model.
module tb_vga_layer_compositor;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int SD = 8;
  localparam int FD = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           pixel_tick;
  logic           video_on;
  logic           hsync_in;
  logic           vsync_in;
  logic [N-1:0]   layer_on;
  logic [N*W-1:0] layer_rgb;
  logic [N-1:0]   layer_en;
  logic [2*N-1:0] blink_sel;
  logic           hsync;
  logic           vsync;
  logic [W-1:0]   rgb;
  logic           blink_slow;
  logic           blink_fast;

  vga_layer_compositor #(
    .NUM_LAYERS (N),
    .RGB_W      (W),
    .SLOW_DIV   (SD),
    .FAST_DIV   (FD),
    .BG_COLOR   (12'h000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .layer_on   (layer_on),
    .layer_rgb  (layer_rgb),
    .layer_en   (layer_en),
    .blink_sel  (blink_sel),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .blink_slow (blink_slow),
    .blink_fast (blink_fast)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference state: clocks since reset release, phases, sticky "a wrap happened since the last frame".
  int         clocks_since_reset;
  int         clk_count;
  bit         ph_slow, ph_fast, wrapped_slow, wrapped_fast, vs_prev;
  logic [W-1:0] m_rgb;
  bit         m_hs, m_vs;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic logic [W-1:0] dim_color(input logic [W-1:0] c);
    int r, g, b;
    r = (int'(c) / 256) % 16;
    g = (int'(c) / 16) % 16;
    b = int'(c) % 16;
    return W'((r / 2) * 256 + (g / 2) * 16 + (b / 2));
  endfunction

  function automatic logic [W-1:0] ref_pixel();
    bit g;
    logic [1:0] sel;
    if (!video_on) return '0;
    for (int i = 0; i < N; i++) begin
      sel = blink_sel[2*i +: 2];
      if (sel == 2'd0)      g = 1'b1;
      else if (sel == 2'd1) g = ph_slow;
      else if (sel == 2'd2) g = ph_fast;
      else                  g = !ph_fast;
      if (layer_on[i] && layer_en[i]) begin
        if (g) return layer_rgb[i*W +: W];
`ifdef VGA_COMP_DIM_EN
        return dim_color(layer_rgb[i*W +: W]);
`endif
      end
    end
    return 12'h000;
  endfunction

  function automatic void model_reset();
    clocks_since_reset = 0;
    ph_slow = 0; ph_fast = 0; wrapped_slow = 0; wrapped_fast = 0;
    vs_prev = 1; m_rgb = '0; m_hs = 1; m_vs = 1;
  endfunction

  // Advance one clock from a falling edge, predict, then compare just after the rising edge.
  task automatic applyStimulus();
    bit frame, wrap_s, wrap_f;
    pixel_tick = (clk_count % 4 == 3);
    frame = vs_prev && !vsync_in;
    if (pixel_tick) begin
      m_rgb = ref_pixel();
      m_hs  = hsync_in;
      m_vs  = vsync_in;
    end
    wrap_s = (clocks_since_reset % SD) == SD - 1;
    wrap_f = (clocks_since_reset % FD) == FD - 1;
    clocks_since_reset++;
    if (frame) begin
      if (wrapped_slow || wrap_s) ph_slow = !ph_slow;
      if (wrapped_fast || wrap_f) ph_fast = !ph_fast;
      wrapped_slow = 0;
      wrapped_fast = 0;
    end else begin
      if (wrap_s) wrapped_slow = 1;
      if (wrap_f) wrapped_fast = 1;
    end
    vs_prev = vsync_in;
    @(posedge clock);
    #1;
    clk_count++;
    checkOutput("rgb", 32'(rgb), 32'(m_rgb));
    checkOutput("hsync", 32'(hsync), 32'(m_hs));
    checkOutput("vsync", 32'(vsync), 32'(m_vs));
    checkOutput("blink_slow", 32'(blink_slow), 32'(ph_slow));
    checkOutput("blink_fast", 32'(blink_fast), 32'(ph_fast));
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Asynchronous reset a little after a falling edge, checked before the next rising edge.
  task automatic pulseReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_rgb", 32'(rgb), 32'h0);
    checkOutput("reset_hsync", 32'(hsync), 32'h1);
    checkOutput("reset_vsync", 32'(vsync), 32'h1);
    checkOutput("reset_blink_slow", 32'(blink_slow), 32'h0);
    checkOutput("reset_blink_fast", 32'(blink_fast), 32'h0);
    repeat (3) @(negedge clock);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic setSteady();
    layer_en  = '1;
    blink_sel = '0;
    video_on  = 1'b1;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
  endtask

  initial begin
    reset = 1'b1; pixel_tick = 0; video_on = 1; hsync_in = 1; vsync_in = 1;
    layer_on = '0; layer_rgb = '0; layer_en = '1; blink_sel = '0;
    clk_count = 0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run(6);

    // Reset asserted mid-line with a visible layer driving the pipe.
    layer_on = 4'b0001; layer_rgb = 48'h000_000_000_ABC; hsync_in = 0;
    run(5);
    pulseReset();
    run(3);

    // Priority: layer 1 beats layer 2, empty -> background, blanking -> black.
    setSteady();
    layer_on  = 4'b0110;
    layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'h123};
    run(4);
    checkOutput("prio_l1", 32'(rgb), 32'hF00);
    layer_on = 4'b0000;
    run(4);
    checkOutput("bg", 32'(rgb), 32'h000);
    layer_on = 4'b1111; video_on = 0;
    run(4);
    checkOutput("blank", 32'(rgb), 32'h000);

    // Wraps without a frame start must not toggle; the next vsync fall does.
    @(negedge clock);
    pulseReset();
    setSteady();
    run(20);
    checkOutput("no_frame_fast", 32'(blink_fast), 32'h0);
    vsync_in = 0;
    run(1);
    checkOutput("frame_fast", 32'(blink_fast), 32'h1);

    // Wrap coinciding with frame start: one toggle, then no toggle without a new wrap.
    @(negedge clock);
    pulseReset();
    setSteady();
    run(3);
    vsync_in = 0;
    run(1);
    checkOutput("coincide_fast", 32'(blink_fast), 32'h1);
    vsync_in = 1;
    run(2);
    vsync_in = 0;
    run(1);
    checkOutput("no_rewrap_fast", 32'(blink_fast), 32'h1);

    // Slow-blinking top layer over a steady layer.
    @(negedge clock);
    pulseReset();
    setSteady();
    layer_on  = 4'b0011;
    layer_rgb = {12'h000, 12'h000, 12'h00F, 12'hFFF};
    blink_sel = 8'b00_00_00_01;
    run(8);
    vsync_in = 0;
    run(5);
    checkOutput("blink_on_slow", 32'(blink_slow), 32'h1);
    checkOutput("blink_on_rgb", 32'(rgb), 32'hFFF);
    vsync_in = 1;
    run(8);
    vsync_in = 0;
    run(5);
    checkOutput("blink_off_slow", 32'(blink_slow), 32'h0);
`ifdef VGA_COMP_DIM_EN
    checkOutput("blink_off_rgb", 32'(rgb), 32'h777);
`else
    checkOutput("blink_off_rgb", 32'(rgb), 32'h00F);
`endif

    // Sync pulses show up one pixel tick later alongside rgb.
    vsync_in = 1; hsync_in = 0;
    run(4);
    checkOutput("hsync_low", 32'(hsync), 32'h0);
    hsync_in = 1; vsync_in = 0;
    run(4);
    checkOutput("vsync_low", 32'(vsync), 32'h0);
    checkOutput("hsync_high", 32'(hsync), 32'h1);

    // Randomized traffic with an occasional mid-frame reset.
    for (int i = 0; i < 1500; i++) begin
      layer_on  = N'($urandom());
      layer_en  = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '1;
      blink_sel = (2*N)'($urandom());
      layer_rgb = (N*W)'({$urandom(), $urandom()});
      video_on  = ($urandom_range(0, 7) != 0);
      hsync_in  = ($urandom_range(0, 3) != 0);
      vsync_in  = ($urandom_range(0, 9) != 0);
      if (i == 700) pulseReset();
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
